prog_fifo: RTL and testbench



---
 rtl/prog_fifo_if.sv | 37 +++
 rtl/prog_fifo.sv | 123 ++++++++++++
 tb/tb_prog_fifo.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/prog_fifo_if.sv
// Bus bundle between the loader/host (master) and prog_fifo (slave).
// master: drives clear, data_in, WR, RD, PC; observes data_out, rd_valid,
//         pc_data, full, empty, almost_full, count, overflow, underflow.
// slave : the FIFO side, mirror image of master.
interface prog_fifo_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 32
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic              clear;
   logic [DATA_W-1:0] data_in;
   logic              WR;
   logic              RD;
   logic [AW-1:0]     PC;
   logic [DATA_W-1:0] data_out;
   logic              rd_valid;
   logic [DATA_W-1:0] pc_data;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic [AW:0]       count;
   logic              overflow;
   logic              underflow;

   modport master (
      output clear, data_in, WR, RD, PC,
      input  data_out, rd_valid, pc_data, full, empty, almost_full, count,
             overflow, underflow
   );

   modport slave (
      input  clear, data_in, WR, RD, PC,
      output data_out, rd_valid, pc_data, full, empty, almost_full, count,
             overflow, underflow
   );
endinterface

// File: rtl/prog_fifo.sv
// prog_fifo: parametrised program/data FIFO for the 8-bit CPU.
// Register-array storage with a registered read port (1-cycle latency),
// occupancy count, almost-full, sticky overflow/underflow and synchronous
// clear. Optional absolute-address read port selected by the macro
// PROG_FIFO_PC_READ_EN (pc_data = mem[PC]); when undefined pc_data is 0.
// Ports:
//   CPU_Clk  - clock, rising edge
//   Reset_n  - synchronous active-low reset
//   bus      - prog_fifo_if.slave (clear, data_in, WR, RD, PC in;
//              data_out, rd_valid, pc_data, full, empty, almost_full,
//              count, overflow, underflow out)
module prog_fifo #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned DEPTH     = 32,
   parameter int unsigned AFULL_LVL = DEPTH - 2
) (
   input  logic       CPU_Clk,
   input  logic       Reset_n,
   prog_fifo_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] AFULL_C = (AW+1)'(AFULL_LVL);
   localparam logic [AW:0] ONE_C   = (AW+1)'(1);

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              rd_valid_q, rd_valid_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;

   logic [AW-1:0]     wr_addr_c, rd_addr_c;
   logic              full_c, empty_c, wr_acc_c, rd_acc_c;

   // Pointer decode: wrap bit distinguishes full from empty.
   assign wr_addr_c = wr_ptr_q[AW-1:0];
   assign rd_addr_c = rd_ptr_q[AW-1:0];
   assign full_c    = (wr_addr_c == rd_addr_c) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign empty_c   = (wr_ptr_q == rd_ptr_q);
   assign wr_acc_c  = bus.WR && !full_c;
   assign rd_acc_c  = bus.RD && !empty_c;

   // Next-state logic; clear overrides any request.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      data_out_d  = data_out_q;
      rd_valid_d  = 1'b0;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (bus.clear) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (wr_acc_c) wr_ptr_d = wr_ptr_q + ONE_C;
         if (rd_acc_c) begin
            rd_ptr_d   = rd_ptr_q + ONE_C;
            data_out_d = mem_q[rd_addr_c];
            rd_valid_d = 1'b1;
         end
         case ({wr_acc_c, rd_acc_c})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
         endcase
         overflow_d  = overflow_q  | (bus.WR && full_c);
         underflow_d = underflow_q | (bus.RD && empty_c);
      end
   end

   // Control and read-port registers.
   always_ff @(posedge CPU_Clk) begin
      if (!Reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         data_out_q  <= '0;
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         data_out_q  <= data_out_d;
         rd_valid_q  <= rd_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage: zeroed by reset, untouched by clear.
   always_ff @(posedge CPU_Clk) begin
      if (!Reset_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (!bus.clear && wr_acc_c) begin
         mem_q[wr_addr_c] <= bus.data_in;
      end
   end

   assign bus.data_out    = data_out_q;
   assign bus.rd_valid    = rd_valid_q;
   assign bus.count       = count_q;
   assign bus.full        = full_c;
   assign bus.empty       = empty_c;
   assign bus.almost_full = (count_q >= AFULL_C);
   assign bus.overflow    = overflow_q;
   assign bus.underflow   = underflow_q;

`ifdef PROG_FIFO_PC_READ_EN
   assign bus.pc_data = mem_q[bus.PC];
`else
   assign bus.pc_data = '0;
`endif

endmodule

// File: tb/tb_prog_fifo.sv
// Testbench for prog_fifo: directed sequence plus randomized traffic, checked
// against a queue-based reference model.
module tb_prog_fifo;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned DEPTH     = 32;
   localparam int unsigned AW        = $clog2(DEPTH);
   localparam int unsigned AFULL_LVL = DEPTH - 2;

   logic CPU_Clk = 1'b0;
   logic Reset_n;

   prog_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   prog_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_LVL(AFULL_LVL)) dut (
      .CPU_Clk (CPU_Clk),
      .Reset_n (Reset_n),
      .bus     (bus.slave)
   );

   always #5 CPU_Clk = ~CPU_Clk;

   // Reference model state.
   logic [DATA_W-1:0] q_m [$];
   logic [DATA_W-1:0] mem_m [DEPTH];
   int                waddr_m;
   logic [DATA_W-1:0] dout_m;
   bit                rv_m, ovf_m, udf_m;

   int checks = 0;
   int passes = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_all();
      logic [DATA_W-1:0] pc_exp;
`ifdef PROG_FIFO_PC_READ_EN
      pc_exp = mem_m[bus.PC];
`else
      pc_exp = '0;
`endif
      chk("count",       32'(bus.count),       32'(q_m.size()));
      chk("empty",       32'(bus.empty),       32'(q_m.size() == 0));
      chk("full",        32'(bus.full),        32'(q_m.size() == DEPTH));
      chk("almost_full", 32'(bus.almost_full), 32'(q_m.size() >= AFULL_LVL));
      chk("overflow",    32'(bus.overflow),    32'(ovf_m));
      chk("underflow",   32'(bus.underflow),   32'(udf_m));
      chk("rd_valid",    32'(bus.rd_valid),    32'(rv_m));
      chk("data_out",    32'(bus.data_out),    32'(dout_m));
      chk("pc_data",     32'(bus.pc_data),     32'(pc_exp));
   endtask

   // One clock cycle: drive, clock, advance the model, compare.
   task automatic cyc(input bit wr, input bit rd, input bit clr,
                      input logic [DATA_W-1:0] d, input logic [AW-1:0] pc);
      bit was_full, was_empty;
      bus.WR = wr; bus.RD = rd; bus.clear = clr; bus.data_in = d; bus.PC = pc;
      @(posedge CPU_Clk);
      if (clr) begin
         q_m.delete();
         ovf_m = 0; udf_m = 0; rv_m = 0; waddr_m = 0;
      end else begin
         was_full  = (q_m.size() == DEPTH);
         was_empty = (q_m.size() == 0);
         rv_m = 0;
         if (rd && !was_empty) begin
            dout_m = q_m.pop_front();
            rv_m   = 1;
         end
         if (wr && !was_full) begin
            q_m.push_back(d);
            mem_m[waddr_m] = d;
            waddr_m = (waddr_m + 1) % DEPTH;
         end
         if (wr && was_full)  ovf_m = 1;
         if (rd && was_empty) udf_m = 1;
      end
      #1;
      check_all();
   endtask

   task automatic do_reset();
      Reset_n = 1'b0;
      bus.WR = 1'b1; bus.RD = 1'b1; bus.clear = 1'b0;
      bus.data_in = DATA_W'($urandom); bus.PC = AW'($urandom);
      @(posedge CPU_Clk);
      q_m.delete();
      foreach (mem_m[i]) mem_m[i] = '0;
      waddr_m = 0; dout_m = '0; rv_m = 0; ovf_m = 0; udf_m = 0;
      #1;
      check_all();
      Reset_n = 1'b1;
   endtask

   function automatic logic [AW-1:0] rpc();
      return AW'($urandom_range(0, DEPTH - 1));
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pushed;
      int budget;
      bit w, r;
      do_reset();

      // Fill 0x00..0x1F, then one write too many.
      for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, DATA_W'(i), rpc());
      cyc(1, 0, 0, 8'hEE, rpc());
      chk("fill_count", 32'(bus.count), 32'(DEPTH));

      // Drain in order, then one read too many.
      for (int i = 0; i < DEPTH; i++) cyc(0, 1, 0, 8'h00, rpc());
      cyc(0, 1, 0, 8'h00, rpc());
      chk("drain_hold", 32'(bus.data_out), 32'h1F);

      // Simultaneous read/write at count 5, on full and on empty.
      cyc(0, 0, 1, 8'h00, rpc());
      for (int i = 0; i < 5; i++) cyc(1, 0, 0, DATA_W'($urandom), rpc());
      for (int i = 0; i < 10; i++) cyc(1, 1, 0, DATA_W'($urandom), rpc());
      while (q_m.size() < DEPTH) cyc(1, 0, 0, DATA_W'($urandom), rpc());
      cyc(1, 1, 0, DATA_W'($urandom), rpc());
      chk("full_wrrd_count", 32'(bus.count), 32'(DEPTH - 1));
      while (q_m.size() > 0) cyc(0, 1, 0, 8'h00, rpc());
      cyc(1, 1, 0, DATA_W'($urandom), rpc());
      chk("empty_wrrd_count", 32'(bus.count), 32'd1);

      // Wrap: 100 pushes with occupancy held between 3 and 29.
      cyc(0, 0, 1, 8'h00, rpc());
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, DATA_W'($urandom), rpc());
      pushed = 0; budget = 0;
      while (pushed < 100 && budget < 2000) begin
         w = 1'($urandom); r = 1'($urandom);
         if (q_m.size() <= 3)  r = w ? 1'b1 : 1'b0;
         if (q_m.size() >= 29) w = r ? 1'b1 : 1'b0;
         if (w) pushed++;
         cyc(w, r, 0, DATA_W'($urandom), rpc());
         budget++;
      end
      chk("wrap_budget", 32'(pushed >= 100), 32'd1);

      // Clear mid-stream; next write lands at address 0.
      cyc(1, 1, 1, 8'h77, rpc());
      cyc(1, 0, 0, 8'h5A, 5'd0);
      cyc(0, 0, 0, 8'h00, 5'd0);

      // Absolute read port: 0xA5 at address 7.
      cyc(0, 0, 1, 8'h00, rpc());
      for (int i = 0; i < 7; i++) cyc(1, 0, 0, DATA_W'($urandom), 5'd7);
      cyc(1, 0, 0, 8'hA5, 5'd7);
`ifdef PROG_FIFO_PC_READ_EN
      chk("pc_a5", 32'(bus.pc_data), 32'hA5);
`else
      chk("pc_off", 32'(bus.pc_data), 32'h0);
`endif

      // Random traffic with occasional clears.
      for (int i = 0; i < 400; i++)
         cyc(1'($urandom), 1'($urandom), $urandom_range(0, 49) == 0,
             DATA_W'($urandom), rpc());

      // Reset mid-stream wipes storage too.
      for (int i = 0; i < 6; i++) cyc(1, 0, 0, DATA_W'($urandom | 1), rpc());
      do_reset();
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 8'h00, AW'(i));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
